// File: rtl/fetch_issue_pkg.sv
// Shared opcodes, NOP word and instruction-buffer entry type
// for the dual-issue fetch front end.
package fetch_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ibuf_entry_t;

endpackage

// File: rtl/fetch_issue_if.sv
// Instruction memory port: fetch address out, two
// combinational words (addr, addr+4) back.
interface fetch_issue_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd0;
  logic [31:0] imem_rd1;

  modport master (
    output imem_addr,
    input  imem_rd0,
    input  imem_rd1
  );

  modport slave (
    input  imem_addr,
    output imem_rd0,
    output imem_rd1
  );
endinterface

// File: rtl/fetch_issue_instr_buffer.sv
// Circular FIFO of {instr, pc}: two writes and up
// to two reads per cycle, head pair always visible.
module instr_buffer
  import fetch_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  ibuf_entry_t              wr0,
  input  ibuf_entry_t              wr1,
  input  logic [1:0]               npop,
  output ibuf_entry_t              rd0,
  output ibuf_entry_t              rd1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ibuf_entry_t    mem [DEPTH];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic           wr;

  assign wr = push & ~flush & ~reset;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[tail]          <= wr0;
      mem[tail + AW'(1)] <= wr1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(npop);
      if (push)
        tail <= tail + AW'(2);
      count <= count
             + (push ? CW'(2) : CW'(0))
             - CW'(npop);
    end
  end

  assign rd0 = mem[head];
  assign rd1 = mem[head + AW'(1)];

endmodule

// File: rtl/fetch_issue.sv
// Two-wide fetch into an instruction buffer, with in-order
// dual issue into decode when slot 2 has no hazard on slot 1.
module fetch_issue
  import fetch_issue_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stalld,
  input  logic         pcsrcd,
  input  logic [31:0]  pcbranchd,
  fetch_issue_if.master imem,
  output logic [31:0]  instrd,
  output logic [31:0]  instrd2,
  output logic [31:0]  pcplus4d,
  output logic [31:0]  pcplus4d2
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          redirect;
  logic          fetch;
  logic          pair_ok;
  logic [1:0]    npop;
  logic [4:0]    dst1;
  logic [4:0]    dst2;
  ibuf_entry_t   head0;
  ibuf_entry_t   head1;
  ibuf_entry_t   wr0;
  ibuf_entry_t   wr1;

  // register 0 doubles as "no destination"
  function automatic logic [4:0] dest_of(
    input logic [31:0] i
  );
    logic [4:0] d;
    d = 5'd0;
    unique case (1'b1)
      i[31:26] == OP_RTYPE: d = i[15:11];
      i[31:26] == OP_LW,
      i[31:26] == OP_ADDI:  d = i[20:16];
      default:              d = 5'd0;
    endcase
    return d;
  endfunction

  assign imem.imem_addr = pc;

  assign free     = CW'(BUF_DEPTH) - count;
  assign redirect = pcsrcd & ~stalld;
  assign fetch    = (free >= CW'(2)) & ~redirect;

  assign wr0 = {imem.imem_rd0, pc};
  assign wr1 = {imem.imem_rd1, pc + 32'd4};

  assign dst1 = dest_of(head0.instr);
  assign dst2 = dest_of(head1.instr);

  always_comb begin
    pair_ok = 1'b1;
    if (head0.instr[31:26] == OP_BEQ ||
        head0.instr[31:26] == OP_J)
      pair_ok = 1'b0;
    if (dst1 != 5'd0 &&
        (dst1 == head1.instr[25:21] ||
         dst1 == head1.instr[20:16] ||
         dst1 == dst2))
      pair_ok = 1'b0;
  end

  always_comb begin
    npop = 2'd0;
    if (!stalld && !redirect) begin
      if (count >= CW'(2) && pair_ok)
        npop = 2'd2;
      else if (count != '0)
        npop = 2'd1;
    end
  end

  instr_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (fetch),
    .wr0   (wr0),
    .wr1   (wr1),
    .npop  (npop),
    .rd0   (head0),
    .rd1   (head1),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset)
      pc <= '0;
    else if (redirect)
      pc <= pcbranchd;
    else if (fetch)
      pc <= pc + 32'd8;
  end

  // bubbles keep the last PCs; only issued slots move them
  always_ff @(posedge clk) begin
    if (reset) begin
      instrd    <= NOP;
      instrd2   <= NOP;
      pcplus4d  <= '0;
      pcplus4d2 <= '0;
    end else if (!stalld) begin
      instrd  <= NOP;
      instrd2 <= NOP;
      case (npop)
        2'd2: begin
          instrd    <= head0.instr;
          instrd2   <= head1.instr;
          pcplus4d  <= head0.pc + 32'd4;
          pcplus4d2 <= head1.pc + 32'd4;
        end
        2'd1: begin
          instrd    <= head0.instr;
          pcplus4d  <= head0.pc + 32'd4;
          pcplus4d2 <= head0.pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_issue.md
FETCH_ISSUE -- requirements
Module: fetch_issue

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 4, instruction-buffer entries (power of two, >=4).
REQ-002 SHALL have ports clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 SHALL have stalld  in  1  hold decode registers, no issue this cycle.
REQ-004 SHALL have pcsrcd  in  1  taken branch/jump resolved in decode; pcbranchd  in  32  redirect target.
REQ-005 SHALL have imem_addr  out  32  fetch address; imem_rd0, imem_rd1  in  32 each  combinational words at imem_addr and imem_addr+4.
REQ-006 SHALL have instrd, instrd2  out  32 each  slot-1/slot-2 instructions to decode.
REQ-007 SHALL have pcplus4d, pcplus4d2  out  32 each  PC+4 of each slot instruction.

Function
REQ-008 SHALL hold fetch PC register pc; imem_addr = pc.
REQ-009 SHALL fetch when free entries (measured at cycle start, pops ignored) >=2 and no accepted redirect: push {imem_rd0, pc} then {imem_rd1, pc+4}, pc <= pc+8.
REQ-010 SHALL, with free <2, not push and hold pc.
REQ-011 SHALL, when stalld=0, issue from buffer head into decode registers at the clock edge.
REQ-012 SHALL issue two entries when count>=2 and pairing permitted (REQ-013/014); one entry (slot 2 = 32'h0, pcplus4d2 = slot-1 PC+4) when count==1 or pairing refused; bubble (both 32'h0, PCs unchanged) when count==0.
REQ-013 Destination of slot 1: opcode 0 -> rd[15:11]; lw/addi -> rt[20:16]; sw/beq/j -> none; register 0 never a destination.
REQ-014 SHALL refuse pairing when slot-1 destination equals slot-2 rs, rt or destination, or slot-1 opcode is beq or j.
REQ-015 SHALL, when stalld=1, hold instrd, instrd2, pcplus4d, pcplus4d2 and pop nothing; fetch continues per REQ-009.
REQ-016 SHALL, on pcsrcd=1 with stalld=0: empty buffer, pc <= pcbranchd, suppress this cycle's fetch, load decode registers with bubble (32'h0, PCs held).
REQ-017 SHALL ignore pcsrcd while stalld=1.
REQ-018 Buffer pointers SHALL wrap modulo BUF_DEPTH; count SHALL never exceed BUF_DEPTH nor underflow.
REQ-019 Latency: word fetched in cycle N reaches instrd/instrd2 at cycle N+2 absent stall/redirect.
REQ-020 Sustained throughput with no pairing refusals SHALL be two instructions per cycle.

Reset
REQ-021 While reset=1 at a clock edge: pc<=0, buffer empty, instrd=instrd2=0, pcplus4d=pcplus4d2=0; no fetch or issue that cycle.
REQ-022 Reset asserted mid-operation SHALL discard all buffered instructions and any pending redirect.

Structure
REQ-023 Opcode constants (OP_RTYPE 6'h00, OP_LW 6'h23, OP_SW 6'h2B, OP_BEQ 6'h04, OP_ADDI 6'h08, OP_J 6'h02) and NOP 32'h0 SHALL live in the shared package.
REQ-024 SHALL instantiate one sub-module instr_buffer: BUF_DEPTH-entry FIFO of {instr, pc}, 2-write/2-read per cycle, with count output.
REQ-025 Pairing check and destination decode SHALL be combinational in fetch_issue.

Verification
REQ-026 Reset release, independent instrs at 0x0/0x4 -> cycle 2: instrd=word@0, instrd2=word@4, pcplus4d=4, pcplus4d2=8.
REQ-027 add $3,$1,$2 then sub $4,$3,$5 -> first pair issues add with instrd2=0; next cycle instrd=sub, pcplus4d=8.
REQ-028 stalld=1 for 3 cycles with buffer full -> decode outputs frozen, imem_addr frozen, count stays 4; issue resumes in program order.
REQ-029 pcsrcd=1, pcbranchd=0x40 -> next cycle imem_addr=0x40, instrd=instrd2=0; two cycles later instrd=word@0x40.
REQ-030 beq in slot-1 position -> issued alone, instrd2=0; pcsrcd with stalld=1 -> no redirect, pc unchanged.
REQ-031 reset pulse while buffer holds 3 entries -> all outputs 0, count 0, next fetch from 0x0.
